// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array edge feeders.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } feeder_state_t;

  // Base bit index of lane r inside a packed vector of WIDTH-bit lanes.
  function automatic int lane_lsb(input int r, input int width);
    return r * width;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying one lane's data and its valid bit.
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      r_data[0]  <= data_i;
      r_valid[0] <= valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign data_o  = r_data[DEPTH-1];
  assign valid_o = r_valid[DEPTH-1];

endmodule

// File: rtl/systolic_west_skew_feeder.sv
// West-edge feeder: skews lane r by r+1 cycles and drains the skew after the
// last vector of a frame, pulsing done when the deepest lane emits it.
module systolic_west_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [ROWS*WIDTH-1:0] in_data_i,
  input  logic                 in_last_i,
  output logic [ROWS*WIDTH-1:0] west_o,
  output logic [ROWS-1:0]      lane_valid_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CW = $clog2(ROWS + 1);

  feeder_state_t         r_state;
  feeder_state_t         w_state_next;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;
  logic                  r_done;
  logic                  r_busy;
  logic                  w_accept;
  logic [ROWS*WIDTH-1:0] w_lane_d;

  assign in_ready_o = (r_state != ST_DRAIN);
  assign w_accept   = in_valid_i && in_ready_o;
  // Bubbles enter as signed zero so downstream partial sums are untouched.
  assign w_lane_d   = w_accept ? in_data_i : '0;

  for (genvar g = 0; g < ROWS; g++) begin : g_lane
    skew_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(g + 1)
    ) u_dly (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .data_i (w_lane_d[lane_lsb(g, WIDTH) +: WIDTH]),
      .valid_i(w_accept),
      .data_o (west_o[lane_lsb(g, WIDTH) +: WIDTH]),
      .valid_o(lane_valid_o[g])
    );
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE, ST_STREAM: begin
        if (w_accept && in_last_i) begin
          w_state_next = ST_DRAIN;
          w_cnt_next   = CW'(ROWS);
        end else if (w_accept) begin
          w_state_next = ST_STREAM;
        end else begin
          w_state_next = r_state;
        end
      end
      ST_DRAIN: begin
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // done is registered one cycle ahead: it rises as the counter lands on 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= (w_state_next == ST_DRAIN) && (w_cnt_next == CW'(1));
      r_busy  <= (w_state_next != ST_IDLE);
    end
  end

  assign done_o = r_done;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_systolic_west_skew_feeder.sv
// Randomized bench for systolic_west_skew_feeder against a cycle-history model.
module tb_systolic_west_skew_feeder;

  localparam int WIDTH = 8;
  localparam int ROWS  = 4;
  localparam int NCYC  = 400;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [ROWS*WIDTH-1:0] in_data;
  logic                  in_last;
  logic [ROWS*WIDTH-1:0] west;
  logic [ROWS-1:0]       lane_valid;
  logic                  busy;
  logic                  done;

  systolic_west_skew_feeder #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .west_o      (west),
    .lane_valid_o(lane_valid),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle history of what the bench presented and what should have been accepted.
  bit                    rst_h [NCYC];
  bit                    acc_h [NCYC];
  bit                    last_h[NCYC];
  logic [ROWS*WIDTH-1:0] dat_h [NCYC];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit rst_in(input int a, input int b);
    for (int s = a; s <= b; s++) begin
      if (s >= 0 && rst_h[s]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] pack(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  // A frame ending at T holds the feeder in drain for T+1..T+ROWS unless reset intervenes.
  function automatic bit in_drain(input int c);
    for (int k = 1; k <= ROWS; k++) begin
      int t;
      t = c - k;
      if (t >= 0 && acc_h[t] && last_h[t] && !rst_in(t, c - 1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    bit                    frame_open;
    bit                    exp_ready;
    bit                    v;
    bit                    l;
    bit                    r;
    logic [ROWS*WIDTH-1:0] d;
    logic [ROWS*WIDTH-1:0] ew;
    logic [ROWS-1:0]       ev;
    bit                    ed;
    int                    t;

    frame_open = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;

    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      exp_ready = !in_drain(c);

      if (c >= 1) begin
        ew = '0;
        ev = '0;
        for (int ln = 0; ln < ROWS; ln++) begin
          int src;
          src = c - ln - 1;
          if (src >= 0 && acc_h[src] && !rst_in(src, c - 1)) begin
            ev[ln] = 1'b1;
            ew[ln*WIDTH +: WIDTH] = dat_h[src][ln*WIDTH +: WIDTH];
          end
        end
        t  = c - ROWS;
        ed = (t >= 0) && acc_h[t] && last_h[t] && !rst_in(t, c - 1);
        check_eq("west",   32'(west),       32'(ew));
        check_eq("lvalid", 32'(lane_valid), 32'(ev));
        check_eq("done",   32'(done),       32'(ed));
        check_eq("ready",  32'(in_ready),   32'(exp_ready));
        check_eq("busy",   32'(busy),       32'(exp_ready ? frame_open : 1'b1));
      end

      v = 1'b0; l = 1'b0; r = 1'b0; d = $urandom;
      if (c < 3) begin
        r = 1'b1;
      end else if (c == 3) begin
        v = 1'b1; l = 1'b1; d = pack(8'd1, 8'd2, 8'd3, 8'd4);
      end else if (c >= 12 && c <= 15) begin
        v = 1'b1; l = (c == 15);
        d = pack(8'(10*(c-12)), 8'(10*(c-12)+1), 8'(10*(c-12)+2), 8'(10*(c-12)+3));
      end else if (c == 22) begin
        v = 1'b1; d = pack(8'd5, 8'd6, 8'd7, 8'd8);
      end else if (c == 24) begin
        v = 1'b1; l = 1'b1; d = pack(8'd9, 8'd10, 8'd11, 8'd12);
      end else if (c == 30) begin
        v = 1'b1; l = 1'b1; d = pack(8'h80, 8'h7f, 8'h80, 8'h7f);
      end else if (c >= 31 && c <= 34) begin
        v = 1'b1; l = 1'b1;
      end else if (c == 35) begin
        v = 1'b1; d = pack(8'h7f, 8'h80, 8'h7f, 8'h80);
      end else if (c == 36) begin
        v = 1'b1; l = 1'b1; d = pack(8'hff, 8'h01, 8'hfe, 8'h02);
      end else if (c == 45) begin
        v = 1'b1; l = 1'b1; d = pack(8'd21, 8'd22, 8'd23, 8'd24);
      end else if (c == 47) begin
        r = 1'b1;
      end else if (c >= 60 && c < NCYC - 10) begin
        v = ($urandom_range(0, 9) < 6);
        l = ($urandom_range(0, 4) == 0);
        r = ($urandom_range(0, 49) == 0);
      end else begin
        v = 1'b0;
      end

      rst = r; in_valid = v; in_last = l; in_data = d;
      rst_h[c]  = r;
      acc_h[c]  = v && exp_ready && !r;
      last_h[c] = l;
      dat_h[c]  = d;
      if (r) frame_open = 1'b0;
      else if (acc_h[c]) frame_open = !l;

      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
